// File: rtl/speaker_mode_arbiter.sv
// Mode arbiter for the keyboard speaker. It synchronises and debounces the mode switches,
// inserts a mute gap on every mode change, and drives one-hot enables to the mode sources.
module speaker_mode_arbiter #(
    parameter int unsigned NUM_MODES    = 4,
    parameter int unsigned MODE_W       = 3,
    parameter int unsigned DEFAULT_MODE = 0,
    parameter int unsigned DEBOUNCE_CYC = 100000,
    parameter int unsigned MUTE_CYC     = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MODE_W-1:0]    mode_select,
    input  logic [NUM_MODES-1:0] speaker_in,
    output logic                 speaker,
    output logic [MODE_W-1:0]    current_mode,
    output logic [NUM_MODES-1:0] mode_enable,
    output logic                 switching,
    output logic                 mode_changed
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_CYC > MUTE_CYC) ? DEBOUNCE_CYC : MUTE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [MODE_W-1:0] DEF_MODE = MODE_W'(DEFAULT_MODE);
    localparam logic [MODE_W:0]   NUM_M    = (MODE_W + 1)'(NUM_MODES);
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0]  MUTE_LAST = CNT_W'(MUTE_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_MUTE     = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [MODE_W-1:0]      r_sync1, r_sync2;
    logic [MODE_W-1:0]      r_cand, w_cand_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [MODE_W-1:0]      r_mode, w_mode_nxt;
    logic [NUM_MODES-1:0]   r_en, w_en_nxt;
    logic                   r_spk, w_spk_nxt;
    logic                   r_sw, w_sw_nxt;
    logic                   r_chg, w_chg_nxt;
    logic [MODE_W-1:0]      w_mapped;
    logic                   w_sel_spk;

    function automatic logic [NUM_MODES-1:0] onehot(input logic [MODE_W-1:0] idx);
        logic [NUM_MODES-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_MODES; i++) begin
            if (idx == MODE_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Out-of-range switch codes fall back to the default mode
    assign w_mapped = ({1'b0, r_sync2} < NUM_M) ? r_sync2 : DEF_MODE;

    always_comb begin
        w_sel_spk = 1'b0;
        for (int unsigned i = 0; i < NUM_MODES; i++) begin
            if (r_mode == MODE_W'(i)) w_sel_spk = speaker_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= DEF_MODE;
            r_sync2 <= DEF_MODE;
            r_state <= ST_RUN;
            r_cand  <= DEF_MODE;
            r_cnt   <= '0;
            r_mode  <= DEF_MODE;
            r_en    <= onehot(DEF_MODE);
            r_spk   <= 1'b0;
            r_sw    <= 1'b0;
            r_chg   <= 1'b0;
        end else begin
            r_sync1 <= mode_select;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_en    <= w_en_nxt;
            r_spk   <= w_spk_nxt;
            r_sw    <= w_sw_nxt;
            r_chg   <= w_chg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_en_nxt    = r_en;
        w_chg_nxt   = 1'b0;
        w_spk_nxt   = (r_state == ST_MUTE) ? 1'b0 : w_sel_spk;
        case (r_state)
            ST_RUN: begin
                if (w_mapped != r_mode) begin
                    w_cand_nxt  = w_mapped;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (w_mapped == r_mode) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end else if (w_mapped != r_cand) begin
                    w_cand_nxt = w_mapped;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_cnt_nxt   = '0;
                    w_en_nxt    = '0;
                    w_state_nxt = ST_MUTE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_MUTE: begin
                if (r_cnt == MUTE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_mode_nxt  = r_cand;
                    w_en_nxt    = onehot(r_cand);
                    w_chg_nxt   = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_RUN;
            end
        endcase
        w_sw_nxt = (w_state_nxt != ST_RUN);
    end

    assign speaker      = r_spk;
    assign current_mode = r_mode;
    assign mode_enable  = r_en;
    assign switching    = r_sw;
    assign mode_changed = r_chg;

endmodule

// File: tb/tb_speaker_mode_arbiter.sv
// Randomised and directed bench for speaker_mode_arbiter, compared each cycle against a
// cycle-counting behavioural model of the mode-switch rules.
module tb_speaker_mode_arbiter;

    localparam int NM  = 3;
    localparam int MW  = 3;
    localparam int DEF = 0;
    localparam int DEB = 4;
    localparam int MUT = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [MW-1:0] mode_select = '0;
    logic [NM-1:0] speaker_in = '0;
    logic          speaker;
    logic [MW-1:0] current_mode;
    logic [NM-1:0] mode_enable;
    logic          switching;
    logic          mode_changed;

    speaker_mode_arbiter #(
        .NUM_MODES(NM), .MODE_W(MW), .DEFAULT_MODE(DEF),
        .DEBOUNCE_CYC(DEB), .MUTE_CYC(MUT)
    ) dut (
        .clk(clk), .reset(reset), .mode_select(mode_select), .speaker_in(speaker_in),
        .speaker(speaker), .current_mode(current_mode), .mode_enable(mode_enable),
        .switching(switching), .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    // Reference model: raw-input history plus plain counters
    int  m_hist [2];
    int  m_mode, m_cand, m_stable, m_mute_cnt;
    bit  m_pending, m_muting, m_chg, m_spk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int map_code(input int code);
        return (code < NM) ? code : DEF;
    endfunction

    task automatic model_edge();
        int m;
        if (reset) begin
            m_hist[0] = DEF; m_hist[1] = DEF;
            m_mode = DEF; m_cand = DEF; m_stable = 0; m_mute_cnt = 0;
            m_pending = 0; m_muting = 0; m_chg = 0; m_spk = 0;
            return;
        end
        m = map_code(m_hist[1]);
        m_hist[1] = m_hist[0];
        m_hist[0] = int'(mode_select);
        m_spk = m_muting ? 1'b0 : speaker_in[m_mode];
        m_chg = 0;
        if (m_muting) begin
            m_mute_cnt++;
            if (m_mute_cnt == MUT) begin
                m_muting = 0;
                m_mode   = m_cand;
                m_chg    = 1;
            end
        end else if (m_pending) begin
            if (m == m_mode) m_pending = 0;
            else if (m != m_cand) begin
                m_cand = m; m_stable = 0;
            end else begin
                m_stable++;
                if (m_stable == DEB) begin
                    m_pending = 0; m_muting = 1; m_mute_cnt = 0;
                end
            end
        end else if (m != m_mode) begin
            m_pending = 1; m_cand = m; m_stable = 0;
        end
    endtask

    task automatic step(input int sel, input logic [NM-1:0] spk, input logic rst);
        @(negedge clk);
        mode_select = MW'(sel);
        speaker_in  = spk;
        reset       = rst;
        @(posedge clk);
        model_edge();
        #1;
        if (mode_changed === 1'b1) n_pulses++;
        check_eq("speaker", 32'(speaker), 32'(m_spk));
        check_eq("current_mode", 32'(current_mode), 32'(m_mode));
        check_eq("mode_enable", 32'(mode_enable), m_muting ? 32'd0 : (32'd1 << m_mode));
        check_eq("switching", 32'(switching), 32'(m_pending | m_muting));
        check_eq("mode_changed", 32'(mode_changed), 32'(m_chg));
    endtask

    task automatic hold(input int sel, input int cycles);
        for (int k = 0; k < cycles; k++) step(sel, NM'($urandom), 1'b0);
    endtask

    initial begin
        // Reset and first cycle after release
        step(0, 3'b001, 1'b1);
        step(0, 3'b001, 1'b1);
        check_eq("rst_mode", 32'(current_mode), 32'd0);
        check_eq("rst_enable", 32'(mode_enable), 32'd1);
        check_eq("rst_speaker", 32'(speaker), 32'd0);
        step(0, 3'b001, 1'b0);
        check_eq("first_speaker", 32'(speaker), 32'd1);

        // Clean switch 0 -> 1
        n_pulses = 0;
        hold(1, 14);
        check_eq("sw1_mode", 32'(current_mode), 32'd1);
        check_eq("sw1_enable", 32'(mode_enable), 32'b010);
        check_eq("sw1_pulses", 32'(n_pulses), 32'd1);

        // Back to 0, then a two-cycle glitch
        hold(0, 14);
        n_pulses = 0;
        hold(1, 2);
        hold(0, 12);
        check_eq("glitch_mode", 32'(current_mode), 32'd0);
        check_eq("glitch_pulses", 32'(n_pulses), 32'd0);

        // Go to 2, then invalid code 5 falls back to 0
        hold(2, 14);
        check_eq("sw2_mode", 32'(current_mode), 32'd2);
        hold(5, 14);
        check_eq("inv_mode", 32'(current_mode), 32'd0);
        check_eq("inv_enable", 32'(mode_enable), 32'b001);

        // Candidate change mid-debounce
        n_pulses = 0;
        hold(1, 2);
        hold(2, 16);
        check_eq("cand_mode", 32'(current_mode), 32'd2);
        check_eq("cand_pulses", 32'(n_pulses), 32'd1);

        // Reset during mute
        hold(1, 7);
        check_eq("mute_enable", 32'(mode_enable), 32'd0);
        n_pulses = 0;
        step(1, 3'b111, 1'b1);
        check_eq("rstmute_mode", 32'(current_mode), 32'd0);
        check_eq("rstmute_enable", 32'(mode_enable), 32'b001);
        check_eq("rstmute_switching", 32'(switching), 32'd0);
        check_eq("rstmute_speaker", 32'(speaker), 32'd0);
        check_eq("rstmute_pulses", 32'(n_pulses), 32'd0);

        // Random phase: random codes held for random durations, occasional resets
        for (int blk = 0; blk < 300; blk++) begin
            int sel;
            int len;
            sel = int'($urandom_range(0, 7));
            len = int'($urandom_range(1, 14));
            if ($urandom_range(0, 40) == 0) step(sel, NM'($urandom), 1'b1);
            hold(sel, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
